// File: rtl/protocol_pkg.sv
// Shared protocol definitions: SPI transmit FSM states, default SPI timing
// constants and small elaboration-time sizing helpers.
package protocol_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL
    } spi_tx_state_t;

    localparam int SPI_CLK_DIV   = 4;
    localparam int SPI_CSN_LEAD  = 2;
    localparam int SPI_CSN_TRAIL = 2;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_tx_timer.sv
// Loadable down-counter with a zero flag; times the LEAD, HIGH, LOW and TRAIL
// phases of the SPI frame transmitter.
module spi_tx_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/spi_frame_tx.sv
// SPI mode-0 master that shifts a parallel frame out LSB first.
// Define SPI_TX_READBACK_EN to capture spi_miso into rx_frame; otherwise rx_frame is 0.
module spi_frame_tx
    import protocol_pkg::*;
#(
    parameter int FRAME_BITS = 256,
    parameter int CLK_DIV    = SPI_CLK_DIV,
    parameter int CSN_LEAD   = SPI_CSN_LEAD,
    parameter int CSN_TRAIL  = SPI_CSN_TRAIL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  done,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    output logic                  spi_csn,
    input  logic                  spi_miso,
    output logic [FRAME_BITS-1:0] rx_frame
);

    localparam int BIT_W   = clog2_min1(FRAME_BITS);
    localparam int TMR_MAX = max3(CLK_DIV, CSN_LEAD, CSN_TRAIL);
    localparam int TMR_W   = clog2_min1(TMR_MAX);

    localparam logic [TMR_W-1:0] LD_DIV   = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] LD_LEAD  = TMR_W'(CSN_LEAD - 1);
    localparam logic [TMR_W-1:0] LD_TRAIL = TMR_W'(CSN_TRAIL - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    spi_tx_state_t         r_state, w_state_next;
    logic [FRAME_BITS-1:0] r_shift, w_shift_next, w_shifted;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt_next;
    logic                  r_busy, w_busy_next;
    logic                  r_done, w_done_next;
    logic                  r_spi_clk, w_spi_clk_next;
    logic                  r_csn, w_csn_next;
    logic                  w_tmr_load, w_tmr_zero, w_enter_high;
    logic [TMR_W-1:0]      w_tmr_value;

    spi_tx_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_zero  (w_tmr_zero)
    );

    assign w_shifted = r_shift >> 1;

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_spi_clk_next = r_spi_clk;
        w_csn_next     = r_csn;
        w_tmr_load     = 1'b0;
        w_tmr_value    = '0;
        w_enter_high   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next   = LEAD;
                    w_shift_next   = frame;
                    w_bit_cnt_next = '0;
                    w_busy_next    = 1'b1;
                    w_csn_next     = 1'b0;
                    w_tmr_load     = 1'b1;
                    w_tmr_value    = LD_LEAD;
                end
            end
            LEAD: begin
                if (w_tmr_zero) begin
                    w_state_next   = HIGH;
                    w_spi_clk_next = 1'b1;
                    w_tmr_load     = 1'b1;
                    w_tmr_value    = LD_DIV;
                    w_enter_high   = 1'b1;
                end
            end
            HIGH: begin
                if (w_tmr_zero) begin
                    w_spi_clk_next = 1'b0;
                    w_tmr_load     = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = TRAIL;
                        w_tmr_value  = LD_TRAIL;
                    end else begin
                        // Advance data on the falling edge so mosi is stable while spi_clk is high.
                        w_state_next   = LOW;
                        w_shift_next   = w_shifted;
                        w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                        w_tmr_value    = LD_DIV;
                    end
                end
            end
            LOW: begin
                if (w_tmr_zero) begin
                    w_state_next   = HIGH;
                    w_spi_clk_next = 1'b1;
                    w_tmr_load     = 1'b1;
                    w_tmr_value    = LD_DIV;
                    w_enter_high   = 1'b1;
                end
            end
            TRAIL: begin
                if (w_tmr_zero) begin
                    w_state_next = IDLE;
                    w_shift_next = '0;
                    w_busy_next  = 1'b0;
                    w_csn_next   = 1'b1;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_busy_next    = 1'b0;
                w_csn_next     = 1'b1;
                w_spi_clk_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_spi_clk <= 1'b0;
            r_csn     <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_spi_clk <= w_spi_clk_next;
            r_csn     <= w_csn_next;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign spi_clk  = r_spi_clk;
    assign spi_csn  = r_csn;
    assign spi_mosi = r_shift[0];

`ifdef SPI_TX_READBACK_EN
    logic [FRAME_BITS-1:0] r_rx, r_rx_frame, w_rx_next;

    // MSB-in, shift-right: the first bit returned ends up in bit 0.
    assign w_rx_next = w_shifted_rx(r_rx, spi_miso);

    function automatic logic [FRAME_BITS-1:0] w_shifted_rx(input logic [FRAME_BITS-1:0] cur,
                                                           input logic bit_in);
        return (cur >> 1) | (FRAME_BITS'(bit_in) << (FRAME_BITS - 1));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx       <= '0;
            r_rx_frame <= '0;
        end else begin
            if (w_enter_high) begin
                r_rx <= w_rx_next;
            end
            if (w_done_next) begin
                r_rx_frame <= r_rx;
            end
        end
    end

    assign rx_frame = r_rx_frame;
`else
    logic w_unused_miso;
    logic w_unused_enter_high;

    assign w_unused_miso       = spi_miso;
    assign w_unused_enter_high = w_enter_high;
    assign rx_frame            = '0;
`endif

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: stimulus pushes expected frames, a monitor
// checks each completed frame when done pulses.
module tb_spi_frame_tx;

`ifdef SPI_TX_READBACK_EN
    localparam logic [15:0] RX_MASK = 16'hFFFF;
`else
    localparam logic [15:0] RX_MASK = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] frame = 16'h0000;
    logic        busy, done, spi_clk, spi_mosi, spi_csn, spi_miso;
    logic [15:0] rx_frame;

    logic        s_start = 1'b0;
    logic [0:0]  s_frame = 1'b0;
    logic        s_busy, s_done, s_spi_clk, s_spi_mosi, s_spi_csn;
    logic [0:0]  s_rx_frame;
    logic        s_spi_miso = 1'b0;

    always #5 clk = ~clk;

    spi_frame_tx #(
        .FRAME_BITS (16),
        .CLK_DIV    (2),
        .CSN_LEAD   (2),
        .CSN_TRAIL  (2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .frame    (frame),
        .busy     (busy),
        .done     (done),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_csn  (spi_csn),
        .spi_miso (spi_miso),
        .rx_frame (rx_frame)
    );

    spi_frame_tx #(
        .FRAME_BITS (1),
        .CLK_DIV    (1),
        .CSN_LEAD   (2),
        .CSN_TRAIL  (2)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (s_start),
        .frame    (s_frame),
        .busy     (s_busy),
        .done     (s_done),
        .spi_clk  (s_spi_clk),
        .spi_mosi (s_spi_mosi),
        .spi_csn  (s_spi_csn),
        .spi_miso (s_spi_miso),
        .rx_frame (s_rx_frame)
    );

    typedef struct {
        logic [15:0] data;
        logic [15:0] rx;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] rx_exp(input logic [15:0] w);
        return w & RX_MASK;
    endfunction

    // Slave model: presents miso_word LSB first, advancing after each spi_clk fall.
    logic [15:0] miso_word = 16'hBEEF;
    int          miso_idx = 0;
    logic        miso_prev_clk = 1'b0;

    always @(negedge clk) begin
        if (rst || spi_csn) miso_idx = 0;
        else if (miso_prev_clk && !spi_clk) miso_idx++;
        miso_prev_clk = spi_clk;
    end

    assign spi_miso = (!spi_csn && miso_idx < 16) ? miso_word[miso_idx[3:0]] : 1'b0;

    // Monitor: shift-right receiver on spi_clk rises plus timing bookkeeping.
    logic        prev_clk = 1'b0, prev_csn = 1'b1, prev_mosi = 1'b0, done_follow = 1'b0;
    int          rise_cnt = 0, busy_cnt = 0, mosi_bad = 0, csn_hi_run = 0, gap_meas = 0;
    logic [15:0] cap = 16'h0000;
    exp_t        mon_t;

    always @(negedge clk) begin
        if (rst) begin
            rise_cnt    = 0;
            busy_cnt    = 0;
            mosi_bad    = 0;
            cap         = 16'h0000;
            done_follow = 1'b0;
        end else begin
            if (done_follow) begin
                check("done_one_cycle", 32'(done), 32'd0);
                done_follow = 1'b0;
            end
            if (busy) busy_cnt++;
            if (spi_clk && !prev_clk) begin
                cap = {spi_mosi, cap[15:1]};
                rise_cnt++;
            end
            if (spi_clk && prev_clk && spi_mosi !== prev_mosi) mosi_bad++;
            if (!spi_csn && prev_csn) begin
                gap_meas = csn_hi_run;
                rise_cnt = 0;
                cap      = 16'h0000;
                mosi_bad = 0;
            end
            if (done) begin
                n_done++;
                check("done_has_expect", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_t = exp_q.pop_front();
                    check("mosi_bits", 32'(cap), 32'(mon_t.data));
                    check("rise_count", rise_cnt, 16);
                    check("busy_cycles", busy_cnt, 66);
                    check("busy_low_at_done", 32'(busy), 32'd0);
                    check("csn_high_at_done", 32'(spi_csn), 32'd1);
                    check("mosi_stable_clk_high", mosi_bad, 0);
                    check("rx_frame", 32'(rx_frame), 32'(mon_t.rx));
                    if (mon_t.gap >= 0) check("csn_gap", gap_meas, mon_t.gap);
                    $display("frame exp=%h got=%h rises=%0d busy=%0d rx=%h gap=%0d",
                             mon_t.data, cap, rise_cnt, busy_cnt, rx_frame, gap_meas);
                end
                busy_cnt    = 0;
                done_follow = 1'b1;
            end
            csn_hi_run = spi_csn ? csn_hi_run + 1 : 0;
        end
        prev_clk  = spi_clk;
        prev_csn  = spi_csn;
        prev_mosi = spi_mosi;
    end

    task automatic send(input logic [15:0] d, input logic [15:0] m, input int gap, input bit expect_it);
        exp_t e;
        @(negedge clk);
        frame     = d;
        miso_word = m;
        start     = 1'b1;
        if (expect_it) begin
            e.data = d;
            e.rx   = rx_exp(m);
            e.gap  = gap;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    int base;
    int sb, shi, srise, sdone;
    logic smosi, sprev;
    exp_t e3;

    initial begin
        #2 rst = 1'b1;
        #1;
        check("reset_csn", 32'(spi_csn), 32'd1);
        check("reset_clk", 32'(spi_clk), 32'd0);
        check("reset_mosi", 32'(spi_mosi), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rx_frame", 32'(rx_frame), 32'd0);
        check("reset_csn_1bit", 32'(s_spi_csn), 32'd1);
        #20 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic frame; a stray start and frame change mid-transfer must be ignored.
        send(16'hA5C3, 16'hBEEF, -1, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1;
        frame = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done("frame1_done");

        // Loopback-style receive of 1234 with a different readback word.
        send(16'h1234, 16'h5A0F, -1, 1'b1);
        repeat (20) @(negedge clk);
        check("rx_hold", 32'(rx_frame), 32'(rx_exp(16'hBEEF)));
        wait_done("frame2_done");

        // start held high: three back-to-back frames, 1-cycle csn gap each.
        @(negedge clk);
        frame     = 16'h8001;
        miso_word = 16'hBEEF;
        start     = 1'b1;
        e3.data = 16'h8001; e3.rx = rx_exp(16'hBEEF); e3.gap = -1; exp_q.push_back(e3);
        e3.data = 16'h7FFE; e3.gap = 1; exp_q.push_back(e3);
        e3.data = 16'h0F0F; e3.gap = 1; exp_q.push_back(e3);
        base = n_done;
        @(posedge clk);
        #1 frame = 16'h7FFE;
        wait_done("b2b_1");
        @(posedge clk);
        #1 frame = 16'h0F0F;
        wait_done("b2b_2");
        @(posedge clk);
        #1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        wait_done("b2b_3");
        repeat (80) @(negedge clk);
        check("b2b_frame_count", n_done - base, 3);

        // Reset at cycle 20 of a transfer aborts asynchronously.
        send(16'hC0DE, 16'hBEEF, -1, 1'b0);
        base = n_done;
        repeat (19) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_csn", 32'(spi_csn), 32'd1);
        check("abort_clk", 32'(spi_clk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        #15 rst = 1'b0;
        repeat (30) @(negedge clk);
        check("no_done_after_abort", n_done - base, 0);
        send(16'h3C5A, 16'hBEEF, -1, 1'b1);
        wait_done("after_abort_done");

        // One-bit frame, CLK_DIV=1: one 1-cycle spi_clk pulse, busy 5 cycles.
        @(negedge clk);
        s_frame = 1'b1;
        s_start = 1'b1;
        sb = 0; shi = 0; srise = 0; sdone = 0; smosi = 1'b0; sprev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (s_busy) sb++;
            if (s_spi_clk) shi++;
            if (s_spi_clk && !sprev) begin
                srise++;
                smosi = s_spi_mosi;
            end
            if (s_done) sdone++;
            sprev = s_spi_clk;
        end
        check("f1_busy_cycles", sb, 5);
        check("f1_clk_high_cycles", shi, 1);
        check("f1_rises", srise, 1);
        check("f1_mosi", 32'(smosi), 32'd1);
        check("f1_done_count", sdone, 1);
        check("f1_rx_frame", 32'(s_rx_frame), 32'd0);
        $display("frame1bit busy=%0d clk_high=%0d rises=%0d mosi=%0b done=%0d",
                 sb, shi, srise, smosi, sdone);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
